// File: rtl/reg_dump_pkg.sv
// Shared types and sizes for the register-file dump reader.
package reg_dump_pkg;
  localparam int REG_COUNT = 16;
  localparam int REG_W     = 8;
  localparam int IDX_W     = 4;
  localparam logic [IDX_W-1:0] CSUM_IDX = 4'hF;

  typedef enum logic [2:0] {IDLE, READ, HOLD, CSUM, DONE} dump_state_t;
endpackage

// File: rtl/dump_checksum.sv
// XOR accumulator over emitted dump bytes; clear wins over enable, result visible the cycle after enable.
module dump_checksum
  import reg_dump_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clear,
  input  logic             en,
  input  logic [REG_W-1:0] data,
  output logic [REG_W-1:0] sum
);

  always_ff @(posedge CLK) begin
    if (RESET || clear) sum <= '0;
    else if (en)        sum <= sum ^ data;
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Walks FIRST_REG..LAST_REG over the async read port, one beat per READ+HOLD pair (2 cycles min), HOLD stalls on out_ready.
// REG_DUMP_CHECKSUM_EN adds a trailing XOR-checksum beat (idx 4'hF) carrying out_last.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 15
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  output logic             busy,
  output logic             rf_sel,
  output logic [IDX_W-1:0] rf_addr,
  input  logic [REG_W-1:0] rf_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             done
);

  if (FIRST_REG < 0 || LAST_REG > REG_COUNT - 1 || LAST_REG < FIRST_REG) begin : g_param_check
    $error("reg_dump_reader: need 0 <= FIRST_REG <= LAST_REG <= 15");
  end

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

  dump_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [REG_W-1:0] data_q;
  logic [IDX_W-1:0] oidx_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          idx_d   = FIRST_IDX;
        end
      end
      READ: state_d = HOLD;
      HOLD: begin
        if (out_ready) begin
          // Increment only below LAST_IDX so the 4-bit index never wraps.
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 4'd1;
            state_d = READ;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end
      CSUM: if (out_ready) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      idx_q   <= FIRST_IDX;
      data_q  <= '0;
      oidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == READ) begin
        data_q <= rf_data;
        oidx_q <= idx_q;
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign rf_sel  = (state_q == READ);
  assign rf_addr = rf_sel ? idx_q : '0;
  assign done    = (state_q == DONE);

`ifdef REG_DUMP_CHECKSUM_EN
  logic [REG_W-1:0] csum;

  dump_checksum u_csum (
    .CLK   (CLK),
    .RESET (RESET),
    .clear ((state_q == IDLE) && start),
    .en    ((state_q == HOLD) && out_ready),
    .data  (data_q),
    .sum   (csum)
  );

  assign out_valid = (state_q == HOLD) || (state_q == CSUM);
  assign out_data  = (state_q == CSUM) ? csum : data_q;
  assign out_idx   = (state_q == CSUM) ? CSUM_IDX : oidx_q;
  assign out_last  = (state_q == CSUM);
`else
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_idx   = oidx_q;
  assign out_last  = out_valid && (oidx_q == LAST_IDX);
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: expected beats come from a register-file array model,
// a negedge monitor pops and compares every handshake, stall and read-port address.
module tb_reg_dump_reader;
  localparam int FIRST = 2;
  localparam int LAST  = 15;
  localparam int NREG  = LAST - FIRST + 1;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic       CLK;
  logic       RESET;
  logic       start;
  logic       busy;
  logic       rf_sel;
  logic [3:0] rf_addr;
  logic [7:0] rf_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_idx;
  logic       out_last;
  logic       done;

  logic [7:0] rf [16];
  assign rf_data = rf[rf_addr];

  reg_dump_reader #(.FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (start),
    .busy      (busy),
    .rf_sel    (rf_sel),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done)
  );

  typedef struct {
    logic [3:0] idx;
    logic [7:0] data;
    logic       last;
    bit         csum;
  } beat_t;

  beat_t exp_q[$];
  int    exp_dones = 0;
  int    n_checks  = 0;
  int    n_fail    = 0;
  int    rmode     = 4;
  int    stop_idx  = 5;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %s at %0t", name, what, $time);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Ready pattern: 0 always, 1 toggle, 2 random, 3 stall on stop_idx, else never.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = 1'($urandom_range(0, 1));
        3: out_ready = !(out_valid && int'(out_idx) == stop_idx);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic push_expected;
    logic [7:0] x;
    beat_t b;
    x = 8'h00;
    for (int i = FIRST; i <= LAST; i++) begin
      b.idx  = 4'(i);
      b.data = rf[i];
      b.last = (CS == 0) && (i == LAST);
      b.csum = 1'b0;
      exp_q.push_back(b);
      x ^= rf[i];
    end
    if (CS != 0) begin
      b.idx  = 4'hF;
      b.data = x;
      b.last = 1'b1;
      b.csum = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  // Updates the register file and any not-yet-read expected beat (and checksum).
  task automatic rf_write(input int j, input logic [7:0] v);
    logic [7:0] old;
    beat_t b;
    old   = rf[j];
    rf[j] = v;
    for (int k = 0; k < exp_q.size(); k++) begin
      b = exp_q[k];
      if (b.csum) b.data ^= old ^ v;
      else if (int'(b.idx) == j) b.data = v;
      exp_q[k] = b;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_rf_sel"},    rf_sel,    0);
    chk({tag, "_rf_addr"},   rf_addr,   0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data,  0);
    chk({tag, "_out_idx"},   out_idx,   0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_done"},      done,      0);
  endtask

  task automatic issue_start;
    chk("busy_before_start", busy, 0);
    push_expected();
    exp_dones++;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_dump(input bit check_timing, input bit mid_start,
                          input int wr_front, input int wr_reg, input bit rand_wr);
    int k;
    bit fired;
    issue_start();
    k = 1;
    fired = 1'b0;
    while (!done && k < 600) begin
      start = mid_start && (k == 5);
      if (wr_reg >= 0 && !fired && exp_q.size() > 0 && !exp_q[0].csum &&
          int'(exp_q[0].idx) == wr_front) begin
        rf_write(wr_reg, ~rf[wr_reg]);
        fired = 1'b1;
      end
      if (rand_wr && $urandom_range(0, 3) == 0 && exp_q.size() > 0 && !exp_q[0].csum &&
          int'(exp_q[0].idx) < LAST) begin
        rf_write($urandom_range(int'(exp_q[0].idx) + 1, LAST), 8'($urandom));
      end
      tick();
      k++;
    end
    start = 1'b0;
    if (!done) fail_now("done_timeout", "no done pulse within budget");
    else if (check_timing) chk("dump_cycles", k, 2 * NREG + 1 + CS);
    if (done) chk("busy_on_done", busy, 1);
    tick();
    chk("busy_after_done", busy, 0);
  endtask

  // Monitor: compares beats at handshake, stall stability, read-port address and done pulses.
  initial begin
    logic       stalled;
    logic [7:0] sd;
    logic [3:0] si;
    logic       sl;
    beat_t      e;
    stalled = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        stalled = 1'b0;
      end else begin
        if (stalled)
          chk("stall_hold", {out_valid, out_last, out_idx, out_data}, {1'b1, sl, si, sd});
        stalled = out_valid && !out_ready;
        sd = out_data;
        si = out_idx;
        sl = out_last;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_beat", "beat with empty scoreboard");
          else begin
            e = exp_q.pop_front();
            chk("beat", {out_last, out_idx, out_data}, {e.last, e.idx, e.data});
          end
        end
        if (rf_sel) begin
          if (exp_q.size() == 0) fail_now("rf_sel_idle", "read with empty scoreboard");
          else chk("rf_addr", rf_addr, exp_q[0].idx);
        end
        if (done) begin
          if (exp_dones == 0) fail_now("spurious_done", "done pulse not expected");
          else exp_dones--;
        end
      end
    end
  end

  initial begin
    int w;
    RESET = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 8'(8'h10 + i);
    repeat (3) tick();
    check_zero("reset");
    RESET = 1'b0;
    tick();

    rmode = 0;
    run_dump(1'b1, 1'b0, -1, -1, 1'b0);

    rf[2] = 8'd22;
    rf[3] = 8'd13;
    rf[4] = 8'd187;
    rmode = 1;
    run_dump(1'b0, 1'b0, -1, -1, 1'b0);

    rmode = 0;
    run_dump(1'b1, 1'b1, -1, -1, 1'b0);

    run_dump(1'b0, 1'b0, 4, 7, 1'b0);

    // Reset while stalled on idx 5 drops the beat and the done pulse.
    rmode = 3;
    issue_start();
    w = 0;
    while (!(out_valid && int'(out_idx) == stop_idx) && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) fail_now("reach_hold5", "idx 5 beat never presented");
    tick();
    tick();
    RESET = 1'b1;
    tick();
    check_zero("reset_hold");
    exp_q.delete();
    exp_dones = 0;
    RESET = 1'b0;
    rmode = 0;
    tick();
    run_dump(1'b1, 1'b0, -1, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);
      rmode = 2;
      run_dump(1'b0, (r % 2) == 1, -1, -1, 1'b1);
    end

    rmode = 4;
    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 0);
    chk("dones_pending", exp_dones, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
